// File: rtl/bp_be_dcache_req_buffer.sv
// bp_be_dcache_req_buffer: FIFO between the BE memory pipe D$ miss-request
// outputs and the LCE request port. Requests enter in order. Late-arriving
// metadata (way/dirty) is attached to the oldest request that still lacks it.
// An entry is presented to the LCE only once its metadata is present.
// Latency: 1 cycle minimum, measured from the later of request and metadata
// to req_v_o. With BP_DCACHE_REQ_BUFFER_BYPASS_EN there is a 0-cycle
// pass-through when the buffer is empty.
// Backpressure: ready_o drops when count_o==els_p and does not look at
// ready_i. req_v_o/req_o/metadata_o are held until ready_i accepts them.
// Optional macro: BP_DCACHE_REQ_BUFFER_BYPASS_EN (combinational empty-buffer
// pass-through).
// Ports:
//   clk_i, reset_n_i                  clock, async active-low reset
//   req_v_i/req_i/ready_o             request in (valid/ready)
//   metadata_v_i/metadata_i           metadata in (no backpressure)
//   req_v_o/req_o/metadata_o/ready_i  complete head entry out (valid/ready)
//   count_o                           occupied entries
//   meta_err_o                        sticky error: metadata with no request awaiting it
module bp_be_dcache_req_buffer #(
  parameter int req_width_p      = 108,
  parameter int metadata_width_p = 4,
  parameter int els_p            = 2,
  localparam int ptr_width_lp    = $clog2(els_p)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        req_v_i,
  input  logic [req_width_p-1:0]      req_i,
  output logic                        ready_o,
  input  logic                        metadata_v_i,
  input  logic [metadata_width_p-1:0] metadata_i,
  output logic                        req_v_o,
  output logic [req_width_p-1:0]      req_o,
  output logic [metadata_width_p-1:0] metadata_o,
  input  logic                        ready_i,
  output logic [ptr_width_lp:0]       count_o,
  output logic                        meta_err_o
);

  localparam logic [ptr_width_lp-1:0] ptr_one_lp  = ptr_width_lp'(1);
  localparam logic [ptr_width_lp:0]   cnt_one_lp  = (ptr_width_lp+1)'(1);
  localparam logic [ptr_width_lp:0]   cnt_full_lp = (ptr_width_lp+1)'(els_p);

  logic [req_width_p-1:0]      req_mem  [els_p];
  logic [metadata_width_p-1:0] meta_mem [els_p];
  logic [els_p-1:0]            valid_r, meta_valid_r;
  logic [ptr_width_lp-1:0]     rptr, wptr, mptr, attach_idx;
  logic [ptr_width_lp:0]       count_r;
  logic                        meta_err_r;

  logic bypass, enq, deq, awaiting, attach, spurious, head_vld;

`ifdef BP_DCACHE_REQ_BUFFER_BYPASS_EN
  assign bypass = reset_n_i & (count_r == '0) & req_v_i & metadata_v_i & ready_i;
`else
  assign bypass = 1'b0;
`endif

  assign ready_o  = reset_n_i & (count_r != cnt_full_lp);
  assign enq      = req_v_i & ready_o & ~bypass;

  // mptr walks behind wptr in FIFO order. If the entry at mptr is valid and
  // has no metadata, it is the oldest one awaiting metadata.
  assign awaiting   = valid_r[mptr] & ~meta_valid_r[mptr];
  // When nothing is awaiting, metadata can only belong to the request being
  // enqueued in this same cycle.
  assign attach_idx = awaiting ? mptr : wptr;
  assign attach     = metadata_v_i & ~bypass & (awaiting | enq);
  assign spurious   = metadata_v_i & ~bypass & ~awaiting & ~enq;

  assign head_vld = valid_r[rptr] & meta_valid_r[rptr];
  assign deq      = head_vld & ready_i;

  assign req_v_o    = head_vld | bypass;
  assign req_o      = bypass ? req_i      : req_mem[rptr];
  assign metadata_o = bypass ? metadata_i : meta_mem[rptr];
  assign count_o    = count_r;
  assign meta_err_o = meta_err_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr         <= '0;
      wptr         <= '0;
      mptr         <= '0;
      valid_r      <= '0;
      meta_valid_r <= '0;
      count_r      <= '0;
      meta_err_r   <= 1'b0;
    end else begin
      if (enq) begin
        valid_r[wptr]      <= 1'b1;
        meta_valid_r[wptr] <= 1'b0;
        wptr               <= wptr + ptr_one_lp;
      end
      // Placed after the enqueue clear, so metadata attached to the
      // same-cycle entry overrides that clear.
      if (attach) begin
        meta_valid_r[attach_idx] <= 1'b1;
        mptr                     <= attach_idx + ptr_one_lp;
      end
      if (deq) begin
        valid_r[rptr] <= 1'b0;
        rptr          <= rptr + ptr_one_lp;
      end
      if (spurious) meta_err_r <= 1'b1;
      case ({enq, deq})
        2'b10:   count_r <= count_r + cnt_one_lp;
        2'b01:   count_r <= count_r - cnt_one_lp;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry payload is not reset; it is qualified by the valid bits.
  always_ff @(posedge clk_i) begin
    if (enq)    req_mem[wptr]        <= req_i;
    if (attach) meta_mem[attach_idx] <= metadata_i;
  end

endmodule
